fu_agu_sb: RTL

// - Next-gen load/store functional unit: address generation, byte-lane select, load extract/extend, 2-stage pipe (EX, MEM).
// - Adds a parametrised store buffer: stores retire into it and drain to data SRAM when the port is idle.
// - Adds store-to-load forwarding, in-order result tags and optional alignment exceptions.
// - Sits between issue/regfile read and the commit buffer; the CP0 path is not included.

---
 rtl/fu_agu_sb_if.sv | 44 ++++
 rtl/fu_agu_sb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fu_agu_sb_if.sv
// Issue, completion and data-SRAM bundle of the load/store unit.
// The unit attaches through the slave modport; the issuing side and the SRAM model use master.
interface fu_agu_sb_if #(
    parameter int TAG_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_op;
    logic [31:0]      in_imm;
    logic [31:0]      in_rdata1;
    logic [31:0]      in_rdata2;
    logic [TAG_W-1:0] in_tag;
    logic             in_we;
    logic             flush;
    logic             dcache_miss;
    logic             out_valid;
    logic [TAG_W-1:0] out_tag;
    logic             out_rf_we;
    logic [31:0]      out_wdata;
    logic [31:0]      out_vaddr;
    logic [1:0]       out_exc;
    logic             sb_empty;
    logic             data_sram_en;
    logic [3:0]       data_sram_wen;
    logic [31:0]      data_sram_addr;
    logic [31:0]      data_sram_wdata;
    logic [31:0]      data_sram_rdata;

    // Handshake: an op transfers on a rising edge where in_valid && in_ready; the issuer
    // keeps every in_* field stable while in_valid is high and in_ready is low.
    modport master (
        output in_valid, in_op, in_imm, in_rdata1, in_rdata2, in_tag, in_we,
        output flush, dcache_miss, data_sram_rdata,
        input  in_ready, out_valid, out_tag, out_rf_we, out_wdata, out_vaddr, out_exc,
        input  sb_empty, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );

    modport slave (
        input  in_valid, in_op, in_imm, in_rdata1, in_rdata2, in_tag, in_we,
        input  flush, dcache_miss, data_sram_rdata,
        output in_ready, out_valid, out_tag, out_rf_we, out_wdata, out_vaddr, out_exc,
        output sb_empty, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );
endinterface

// File: rtl/fu_agu_sb.sv
// Load/store unit: AGU, EX/MEM pipe, store buffer with store-to-load forwarding.
// Optional macro AGU_MISALIGN_EXC_EN enables AdEL/AdES alignment exceptions.
module fu_agu_sb #(
    parameter int SB_DEPTH = 4,
    parameter int TAG_W    = 6
) (
    input logic        clk,
    input logic        rst,
    fu_agu_sb_if.slave bus
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    logic             ex_valid_q, ex_we_q;
    logic [7:0]       ex_op_q;
    logic [31:0]      ex_vaddr_q, ex_sdata_q;
    logic [TAG_W-1:0] ex_tag_q;

    logic             mem_valid_q, mem_we_q, mem_have_q;
    logic [7:0]       mem_op_q;
    logic [31:0]      mem_vaddr_q, mem_data_q;
    logic [TAG_W-1:0] mem_tag_q;
    logic [1:0]       mem_exc_q;

    logic [29:0]      sb_addr_q [SB_DEPTH];
    logic [3:0]       sb_mask_q [SB_DEPTH];
    logic [31:0]      sb_data_q [SB_DEPTH];
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q;

    logic        ex_load, ex_store, ex_byte, ex_half;
    logic [3:0]  ex_lanes;
    logic [31:0] ex_repl;
    logic [1:0]  ex_exc;

    always_comb begin
        ex_load  = |ex_op_q[7:3];
        ex_store = |ex_op_q[2:0];
        ex_byte  = ex_op_q[7] | ex_op_q[6] | ex_op_q[2];
        ex_half  = ex_op_q[5] | ex_op_q[4] | ex_op_q[1];
        ex_lanes = 4'b1111;
        ex_repl  = ex_sdata_q;
        if (ex_byte) begin
            ex_lanes = 4'b0001 << ex_vaddr_q[1:0];
            ex_repl  = {4{ex_sdata_q[7:0]}};
        end else if (ex_half) begin
            ex_lanes = ex_vaddr_q[1] ? 4'b1100 : 4'b0011;
            ex_repl  = {2{ex_sdata_q[15:0]}};
        end
        ex_exc = 2'b00;
`ifdef AGU_MISALIGN_EXC_EN
        if ((ex_half && ex_vaddr_q[0]) || (!ex_byte && !ex_half && ex_vaddr_q[1:0] != 2'b00))
            ex_exc = ex_store ? 2'b10 : 2'b01;
`endif
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    logic          sb_hit;
    logic [3:0]    hit_mask;
    logic [31:0]   hit_data;
    logic [PW-1:0] idx;

    always_comb begin
        sb_hit   = 1'b0;
        hit_mask = 4'b0000;
        hit_data = 32'h0;
        idx      = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (sb_addr_q[idx] == ex_vaddr_q[31:2])) begin
                sb_hit   = 1'b1;
                hit_mask = sb_mask_q[idx];
                hit_data = sb_data_q[idx];
            end
        end
    end

    logic ex_act_ld, ld_cover, ld_fwd, ld_hold, ex_port, sb_full, pop, st_hold, ex_hold;
    logic fire, ex_adv, push;

    assign ex_act_ld = ex_valid_q && ex_load && (ex_exc == 2'b00);
    assign ld_cover  = (hit_mask & ex_lanes) == ex_lanes;
    assign ld_fwd    = ex_act_ld && sb_hit && ld_cover;
    assign ld_hold   = ex_act_ld && sb_hit && !ld_cover;
    assign ex_port   = ex_act_ld && !sb_hit && !bus.dcache_miss;
    assign sb_full   = (count_q == CW'(SB_DEPTH));
    assign pop       = (count_q != '0) && !bus.dcache_miss && !ex_port;
    assign st_hold   = ex_valid_q && ex_store && (ex_exc == 2'b00) && sb_full && !pop;
    assign ex_hold   = ld_hold || st_hold;
    assign bus.in_ready = !bus.dcache_miss && !ex_hold;
    assign fire      = bus.in_valid && bus.in_ready;
    assign ex_adv    = ex_valid_q && !ex_hold && !bus.dcache_miss && !bus.flush;
    assign push      = ex_adv && ex_store && (ex_exc == 2'b00);

    always_comb begin
        bus.data_sram_en    = 1'b0;
        bus.data_sram_wen   = 4'b0000;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;
        if (ex_port) begin
            bus.data_sram_en   = 1'b1;
            bus.data_sram_addr = {ex_vaddr_q[31:2], 2'b00};
        end else if (pop) begin
            bus.data_sram_en    = 1'b1;
            bus.data_sram_wen   = sb_mask_q[head_q];
            bus.data_sram_addr  = {sb_addr_q[head_q], 2'b00};
            bus.data_sram_wdata = sb_data_q[head_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_we_q     <= 1'b0;
            ex_op_q     <= 8'h0;
            ex_vaddr_q  <= 32'h0;
            ex_sdata_q  <= 32'h0;
            ex_tag_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_have_q  <= 1'b0;
            mem_op_q    <= 8'h0;
            mem_vaddr_q <= 32'h0;
            mem_data_q  <= 32'h0;
            mem_tag_q   <= '0;
            mem_exc_q   <= 2'b00;
        end else begin
            if (bus.flush) begin
                ex_valid_q  <= fire;
                mem_valid_q <= 1'b0;
            end else if (!bus.dcache_miss) begin
                mem_valid_q <= ex_adv;
                if (fire)
                    ex_valid_q <= 1'b1;
                else if (!ex_hold)
                    ex_valid_q <= 1'b0;
            end
            if (fire) begin
                ex_op_q    <= bus.in_op;
                ex_vaddr_q <= bus.in_rdata1 + bus.in_imm;
                ex_sdata_q <= bus.in_rdata2;
                ex_tag_q   <= bus.in_tag;
                ex_we_q    <= bus.in_we;
            end
            if (ex_adv) begin
                mem_op_q    <= ex_op_q;
                mem_vaddr_q <= ex_vaddr_q;
                mem_tag_q   <= ex_tag_q;
                mem_we_q    <= ex_we_q;
                mem_exc_q   <= ex_exc;
                mem_have_q  <= ld_fwd;
                mem_data_q  <= hit_data;
            end else if (!bus.flush && bus.dcache_miss && mem_valid_q && !mem_have_q) begin
                // SRAM read data is only guaranteed in the first MEM cycle; keep it across a freeze.
                mem_have_q <= 1'b1;
                mem_data_q <= bus.data_sram_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_addr_q[i] <= 30'h0;
                sb_mask_q[i] <= 4'h0;
                sb_data_q[i] <= 32'h0;
            end
        end else begin
            if (push) begin
                sb_addr_q[tail_q] <= ex_vaddr_q[31:2];
                sb_mask_q[tail_q] <= ex_lanes;
                sb_data_q[tail_q] <= ex_repl;
                tail_q            <= tail_q + 1'b1;
            end
            if (pop)
                head_q <= head_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    logic        mem_load, mem_ok;
    logic [31:0] ld_word, ld_ext;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    always_comb begin
        mem_load = |mem_op_q[7:3];
        mem_ok   = mem_valid_q && mem_load && (mem_exc_q == 2'b00);
        ld_word  = mem_have_q ? mem_data_q : bus.data_sram_rdata;
        ld_b     = ld_word[8*mem_vaddr_q[1:0] +: 8];
        ld_h     = mem_vaddr_q[1] ? ld_word[31:16] : ld_word[15:0];
        ld_ext   = ld_word;
        if (mem_op_q[7])      ld_ext = {{24{ld_b[7]}}, ld_b};
        else if (mem_op_q[6]) ld_ext = {24'h0, ld_b};
        else if (mem_op_q[5]) ld_ext = {{16{ld_h[15]}}, ld_h};
        else if (mem_op_q[4]) ld_ext = {16'h0, ld_h};
    end

    assign bus.out_valid = mem_valid_q && !bus.dcache_miss;
    assign bus.out_tag   = mem_tag_q;
    assign bus.out_vaddr = mem_vaddr_q;
    assign bus.out_rf_we = bus.out_valid && mem_ok && mem_we_q;
    assign bus.out_wdata = mem_ok ? ld_ext : 32'h0;
    assign bus.out_exc   = mem_valid_q ? mem_exc_q : 2'b00;
    assign bus.sb_empty  = (count_q == '0);
endmodule
